// File: rtl/mac_tap_seq.sv
// Sequences TAPS pixel/weight pairs through an external registered multiplier-adder and emits one window sum.
// Define MAC_OUT_SAT_EN to clamp out_data to all ones (with out_sat) when the sum exceeds OUT_W bits.
module mac_tap_seq #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24,
    parameter int OUT_W  = 16,
    parameter int TAPS   = 9
) (
    input  logic              clock,
    input  logic              aclr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_pixel,
    input  logic [DATA_W-1:0] in_weight,
    output logic [DATA_W-1:0] mult_dataa,
    output logic [DATA_W-1:0] mult_datab,
    output logic [ACC_W-1:0]  mult_sumin,
    output logic              mult_clken,
    output logic              mult_aclr,
    input  logic [ACC_W-1:0]  mult_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_sat
);

    localparam int CNT_W = $clog2(TAPS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TAPS - 1);

    typedef enum logic {ACCUM, DRAIN} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             accept;

`ifdef MAC_OUT_SAT_EN
    localparam logic [ACC_W-1:0] OUT_MAX = ACC_W'((64'd1 << OUT_W) - 64'd1);

    logic out_sat_q;

    function automatic logic [OUT_W:0] sat_out(input logic [ACC_W-1:0] v);
        if (v > OUT_MAX)
            return {1'b1, {OUT_W{1'b1}}};
        return {1'b0, v[OUT_W-1:0]};
    endfunction

    assign out_sat = out_sat_q;
`else
    assign out_sat = 1'b0;
`endif

    assign in_ready   = (state == ACCUM);
    assign accept     = in_valid && in_ready;
    assign mult_dataa = in_pixel;
    assign mult_datab = in_weight;
    // First tap starts the chain from zero; later taps add onto the held partial sum.
    assign mult_sumin = (cnt == '0) ? '0 : mult_result;
    // Multiplier only advances on an accepted pair, so bubbles and stalls keep its sum intact.
    assign mult_clken = accept || aclr;
    assign mult_aclr  = aclr;

    always_ff @(posedge clock) begin
        if (aclr) begin
            state     <= ACCUM;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
`ifdef MAC_OUT_SAT_EN
            out_sat_q <= 1'b0;
`endif
        end else begin
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            case (state)
                ACCUM: begin
                    if (accept) begin
                        if (cnt == LAST) begin
                            cnt   <= '0;
                            state <= DRAIN;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    // Reload only when the output slot is free or being emptied this cycle.
                    if (!out_valid || out_ready) begin
`ifdef MAC_OUT_SAT_EN
                        {out_sat_q, out_data} <= sat_out(mult_result);
`else
                        out_data <= mult_result[OUT_W-1:0];
`endif
                        out_valid <= 1'b1;
                        state     <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_tap_seq.sv
// Directed bench for mac_tap_seq with a 1-cycle registered multiply-add model on the multiplier ports.
module tb_mac_tap_seq;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 24;
    localparam int OUT_W  = 16;
    localparam int TAPS   = 9;

    logic              clock = 1'b0;
    logic              aclr;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_pixel;
    logic [DATA_W-1:0] in_weight;
    logic [DATA_W-1:0] mult_dataa;
    logic [DATA_W-1:0] mult_datab;
    logic [ACC_W-1:0]  mult_sumin;
    logic              mult_clken;
    logic              mult_aclr;
    logic [ACC_W-1:0]  mult_result;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;
    logic              out_sat;

    int ncmp = 0;
    int nerr = 0;

    mac_tap_seq #(.DATA_W(DATA_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .TAPS(TAPS)) dut (
        .clock(clock), .aclr(aclr),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pixel(in_pixel), .in_weight(in_weight),
        .mult_dataa(mult_dataa), .mult_datab(mult_datab), .mult_sumin(mult_sumin),
        .mult_clken(mult_clken), .mult_aclr(mult_aclr), .mult_result(mult_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_sat(out_sat)
    );

    always #5 clock = ~clock;

    // Registered multiply-add: clears on aclr, holds when clken is low.
    always_ff @(posedge clock) begin
        if (mult_aclr)
            mult_result <= '0;
        else if (mult_clken)
            mult_result <= ACC_W'(mult_dataa) * ACC_W'(mult_datab) + mult_sumin;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic feed_n(input int n, input logic [DATA_W-1:0] p, input logic [DATA_W-1:0] w);
        in_valid  = 1'b1;
        in_pixel  = p;
        in_weight = w;
        for (int i = 0; i < n; i++)
            tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        aclr      = 1'b1;
        in_valid  = 1'b0;
        in_pixel  = '0;
        in_weight = '0;
        out_ready = 1'b1;
        tick();
        tick();

        // V6: reset state
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_out_sat", 32'(out_sat), 0);
        chk("rst_mult_result", 32'(mult_result), 0);
        aclr = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_mult_clken", 32'(mult_clken), 0);

        // V1: 2x3 back-to-back
        feed_n(TAPS, 8'd2, 8'd3);
        in_valid = 1'b0;
        chk("v1_drain_in_ready", 32'(in_ready), 0);
        chk("v1_drain_out_valid", 32'(out_valid), 0);
        tick();
        chk("v1_out_valid", 32'(out_valid), 1);
        chk("v1_out_data", 32'(out_data), 54);
        chk("v1_in_ready_back", 32'(in_ready), 1);
        tick();
        chk("v1_out_valid_clr", 32'(out_valid), 0);

        // V2: pixels 1..9 with a bubble after every pair
        for (int i = 1; i <= TAPS; i++) begin
            in_valid  = 1'b1;
            in_pixel  = DATA_W'(i);
            in_weight = 8'd1;
            tick();
            in_valid  = 1'b0;
            in_pixel  = 8'd99;
            in_weight = 8'd99;
            tick();
            if (i == 3)
                chk("v2_bubble_hold", 32'(mult_result), 6);
        end
        chk("v2_out_valid", 32'(out_valid), 1);
        chk("v2_out_data", 32'(out_data), 45);
        tick();

        // V3: full-scale products
        feed_n(TAPS, 8'd255, 8'd255);
        in_valid = 1'b0;
        chk("v3_sum", 32'(mult_result), 585225);
        tick();
`ifdef MAC_OUT_SAT_EN
        chk("v3_out_data", 32'(out_data), 65535);
        chk("v3_out_sat", 32'(out_sat), 1);
`else
        chk("v3_out_data", 32'(out_data), 60937);
        chk("v3_out_sat", 32'(out_sat), 0);
`endif
        tick();

        // V4: downstream stalled across two windows
        out_ready = 1'b0;
        feed_n(2 * TAPS + 1, 8'd1, 8'd1);
        in_valid = 1'b0;
        chk("v4_stall_out_valid", 32'(out_valid), 1);
        chk("v4_stall_out_data", 32'(out_data), 9);
        chk("v4_stall_in_ready", 32'(in_ready), 0);
        tick();
        tick();
        chk("v4_hold_out_data", 32'(out_data), 9);
        chk("v4_hold_in_ready", 32'(in_ready), 0);
        chk("v4_hold_mult_result", 32'(mult_result), 9);
        out_ready = 1'b1;
        tick();
        chk("v4_second_out_valid", 32'(out_valid), 1);
        chk("v4_second_out_data", 32'(out_data), 9);
        chk("v4_second_in_ready", 32'(in_ready), 1);
        tick();
        chk("v4_out_valid_clr", 32'(out_valid), 0);

        // V5: reset mid-window discards the partial sum
        feed_n(4, 8'd5, 8'd5);
        in_valid = 1'b0;
        chk("v5_partial", 32'(mult_result), 100);
        aclr = 1'b1;
        tick();
        aclr = 1'b0;
        chk("v5_out_valid", 32'(out_valid), 0);
        chk("v5_cnt", 32'(dut.cnt), 0);
        chk("v5_mult_result", 32'(mult_result), 0);
        chk("v5_in_ready", 32'(in_ready), 1);
        feed_n(TAPS, 8'd1, 8'd1);
        in_valid = 1'b0;
        tick();
        chk("v5_out_valid_after", 32'(out_valid), 1);
        chk("v5_out_data_after", 32'(out_data), 9);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/mac_tap_seq.md
MAC_TAP_SEQ -- requirements
Module: mac_tap_seq

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- DATA_W, 8, pixel and weight width.
- ACC_W, 24, multiplier sumin/result width.
- OUT_W, 16, output sample width; OUT_W <= ACC_W.
- TAPS, 9, products per window; TAPS >= 2.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clock, in, 1, single clock; all logic on rising edge.
- aclr, in, 1, synchronous active-high reset.
- in_valid, in, 1, pixel/weight pair offered.
- in_ready, out, 1, pair accepted when in_valid && in_ready.
- in_pixel, in, DATA_W, unsigned pixel.
- in_weight, in, DATA_W, unsigned weight.
- mult_dataa, out, DATA_W, to multiplier dataa.
- mult_datab, out, DATA_W, to multiplier datab.
- mult_sumin, out, ACC_W, to multiplier sumin.
- mult_clken, out, 1, to multiplier clken.
- mult_aclr, out, 1, to multiplier aclr.
- mult_result, in, ACC_W, registered multiplier result (1-cycle latency, holds when clken=0).
- out_valid, out, 1, window sum available.
- out_ready, in, 1, downstream accepts when out_valid && out_ready.
- out_data, out, OUT_W, window sum.
- out_sat, out, 1, out_data was saturated.
REQ-003 The block SHALL use one clock (clock); reset (aclr) SHALL be synchronous and active-high.

Function
REQ-004 FSM states SHALL be ACCUM and DRAIN; tap counter cnt SHALL count 0..TAPS-1.
REQ-005 In ACCUM, in_ready SHALL be 1; in DRAIN, in_ready SHALL be 0.
REQ-006 Accept SHALL mean in_valid && in_ready; mult_clken SHALL equal accept || aclr.
REQ-007 mult_dataa/mult_datab SHALL be in_pixel/in_weight combinationally.
REQ-008 mult_sumin SHALL be 0 when cnt==0, else mult_result (chained partial sum).
REQ-009 Each accept SHALL increment cnt; accept at cnt==TAPS-1 SHALL set cnt to 0 and enter DRAIN.
REQ-010 Cycles with in_valid=0 in ACCUM SHALL leave cnt and mult_result unchanged (bubbles do not alter the sum).
REQ-011 In DRAIN with out_valid==0 or out_ready==1, the block SHALL load out_data/out_sat from mult_result, set out_valid=1 and return to ACCUM in the same edge.
REQ-012 In DRAIN with out_valid==1 && out_ready==0, the block SHALL remain in DRAIN, holding out_data and mult_result.
REQ-013 out_valid SHALL clear on out_ready unless a reload (REQ-011) occurs in the same cycle; out_data SHALL be stable while out_valid && !out_ready.
REQ-014 All arithmetic SHALL be unsigned; the window sum is mult_result after the last tap.
REQ-015 Best-case throughput SHALL be one window per TAPS+1 cycles.

Reset
REQ-016 On aclr: state=ACCUM, cnt=0, out_valid=0, out_data=0, out_sat=0.
REQ-017 mult_aclr SHALL equal aclr, which clears mult_result via mult_clken.
REQ-018 aclr mid-window SHALL discard the partial sum; the next window SHALL be computed from zero.

Configuration
REQ-019 With MAC_OUT_SAT_EN defined, mult_result > 2^OUT_W-1 SHALL load out_data = all ones with out_sat=1; otherwise out_data = mult_result with out_sat=0.
REQ-020 Without MAC_OUT_SAT_EN, out_data SHALL be mult_result[OUT_W-1:0] and out_sat SHALL be tied 0.

Verification
REQ-021 Bench SHALL use defaults with an lpm_mult-equivalent 1-cycle registered multiplier model.
- V1: 9 pairs pixel=2, weight=3, back-to-back, out_ready=1 -> out_data=54, out_valid for 1 cycle, in_ready low for exactly 1 cycle.
- V2: pixels 1..9, weights 1, in_valid toggled every other cycle -> out_data=45.
- V3: 9 pairs 255x255 -> with MAC_OUT_SAT_EN out_data=65535, out_sat=1; without, out_data=60937, out_sat=0.
- V4: out_ready=0, two windows of 1x1 -> first out_data=9 held; second window stalls in DRAIN with in_ready=0; raising out_ready delivers 9 then 9.
- V5: aclr for 1 cycle after 4 taps of 5x5 -> out_valid=0, cnt=0; next window of 1x1 gives 9.
- V6: reset -> all outputs 0, in_ready=1 in the first post-reset cycle.
